sap1_display: RTL and testbench



---
 rtl/sap1_display_if.sv | 23 ++
 rtl/sap1_display.sv | 166 ++++++++++++++++
 tb/tb_sap1_display.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/sap1_display_if.sv
// Display-side bundle between the SAP-1 output register and the 7-segment driver.
// Carries the value to show, the hex/decimal select, and the segment/anode drive.
// Exposes the committed BCD result and the conversion-busy flag for observation.
//   master : drives value/hex_mode and observes seg/an/busy/bcd
//   slave  : the display block itself
interface sap1_display_if;
    logic [7:0]  value;
    logic        hex_mode;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        busy;
    logic [11:0] bcd;

    modport master (
        output value, hex_mode,
        input  seg, an, busy, bcd
    );

    modport slave (
        input  value, hex_mode,
        output seg, an, busy, bcd
    );
endinterface

// File: rtl/sap1_display.sv
// Purpose: 8-bit value -> decimal (sequential double-dabble) or hex, scanned onto a 4-digit 7-seg display.
// Latency: bcd/hex commit 9 edges after a value change (1 capture + 8 shifts); seg/an registered, 1 edge.
// Backpressure: none; value changes during a conversion are picked up on the next idle cycle.
// Ports: sysclk (rising-edge clock), fp_clear_n (async active-low reset),
//        dsp.value/hex_mode in; dsp.seg {g..a}, dsp.an (an[0] rightmost), dsp.busy, dsp.bcd out.
module sap1_display #(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic           sysclk,
    input  logic           fp_clear_n,
    sap1_display_if.slave  dsp
);
    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0] FONT_ZERO = 7'b0111111;
    localparam logic [6:0] SEG_RST   = SEG_ACTIVE_LOW ? ~FONT_ZERO : FONT_ZERO;
    localparam logic [3:0] AN_RST    = SEG_ACTIVE_LOW ? 4'b1110 : 4'b0001;

    typedef enum logic {IDLE, CONV} state_t;

    function automatic logic [6:0] font(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b0111111;
            4'h1: s = 7'b0000110;
            4'h2: s = 7'b1011011;
            4'h3: s = 7'b1001111;
            4'h4: s = 7'b1100110;
            4'h5: s = 7'b1101101;
            4'h6: s = 7'b1111101;
            4'h7: s = 7'b0000111;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1101111;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b1111100;
            4'hC: s = 7'b0111001;
            4'hD: s = 7'b1011110;
            4'hE: s = 7'b1111001;
            default: s = 7'b1110001;
        endcase
        return s;
    endfunction

    state_t            state_q, state_d;
    logic [7:0]        captured_q, captured_d;
    logic [19:0]       shift_q, shift_d;
    logic [2:0]        iter_q, iter_d;
    logic [11:0]       bcd_q, bcd_d;
    logic [7:0]        hex_q, hex_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  refresh_q, refresh_d;
    logic [1:0]        digit_q, digit_d;
    logic [6:0]        seg_q, seg_d;
    logic [3:0]        an_q, an_d;

    logic [19:0]       adj;
    logic [19:0]       shifted;
    logic [6:0]        seg_raw;
    logic [3:0]        hund, tens, ones;

    // Converter: capture on mismatch, then 8 add-3/shift steps.
    always_comb begin
        state_d    = state_q;
        captured_d = captured_q;
        shift_d    = shift_q;
        iter_d     = iter_q;
        bcd_d      = bcd_q;
        hex_d      = hex_q;
        busy_d     = busy_q;

        adj = shift_q;
        for (int i = 0; i < 3; i++) begin
            if (shift_q[8 + 4*i +: 4] >= 4'd5)
                adj[8 + 4*i +: 4] = shift_q[8 + 4*i +: 4] + 4'd3;
        end
        shifted = adj << 1;

        case (state_q)
            IDLE: begin
                if (dsp.value != captured_q) begin
                    captured_d = dsp.value;
                    shift_d    = {12'b0, dsp.value};
                    iter_d     = 3'd0;
                    busy_d     = 1'b1;
                    state_d    = CONV;
                end
            end
            CONV: begin
                shift_d = shifted;
                iter_d  = iter_q + 3'd1;
                if (iter_q == 3'd7) begin
                    // Both views commit together so the display never mixes old and new.
                    bcd_d   = shifted[19:8];
                    hex_d   = captured_q;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan: seg is recomputed every cycle for the upcoming digit, so it changes on the
    // same edge as the anode and also picks up fresh results without waiting a slot.
    always_comb begin
        refresh_d = (refresh_q == CNT_MAX) ? '0 : refresh_q + CNT_W'(1);
        digit_d   = (refresh_q == CNT_MAX) ? digit_q + 2'd1 : digit_q;

        hund = bcd_q[11:8];
        tens = bcd_q[7:4];
        ones = bcd_q[3:0];

        seg_raw = 7'b0;
        if (dsp.hex_mode) begin
            case (digit_d)
                2'd0:    seg_raw = font(hex_q[3:0]);
                2'd1:    seg_raw = font(hex_q[7:4]);
                default: seg_raw = 7'b0;
            endcase
        end else begin
            case (digit_d)
                2'd0:    seg_raw = font(ones);
                2'd1:    seg_raw = (hund == 4'd0 && tens == 4'd0) ? 7'b0 : font(tens);
                2'd2:    seg_raw = (hund == 4'd0) ? 7'b0 : font(hund);
                default: seg_raw = 7'b0;
            endcase
        end

        seg_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
        an_d  = SEG_ACTIVE_LOW ? ~(4'b0001 << digit_d) : (4'b0001 << digit_d);
    end

    always_ff @(posedge sysclk or negedge fp_clear_n) begin
        if (!fp_clear_n) begin
            state_q    <= IDLE;
            captured_q <= 8'd0;
            shift_q    <= 20'd0;
            iter_q     <= 3'd0;
            bcd_q      <= 12'd0;
            hex_q      <= 8'd0;
            busy_q     <= 1'b0;
            refresh_q  <= '0;
            digit_q    <= 2'd0;
            seg_q      <= SEG_RST;
            an_q       <= AN_RST;
        end else begin
            state_q    <= state_d;
            captured_q <= captured_d;
            shift_q    <= shift_d;
            iter_q     <= iter_d;
            bcd_q      <= bcd_d;
            hex_q      <= hex_d;
            busy_q     <= busy_d;
            refresh_q  <= refresh_d;
            digit_q    <= digit_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign dsp.seg  = seg_q;
    assign dsp.an   = an_q;
    assign dsp.busy = busy_q;
    assign dsp.bcd  = bcd_q;
endmodule

// File: tb/tb_sap1_display.sv
module tb_sap1_display;
    logic sysclk;
    logic fp_clear_n;

    sap1_display_if ifc ();

    sap1_display #(
        .REFRESH_DIV    (4),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .sysclk     (sysclk),
        .fp_clear_n (fp_clear_n),
        .dsp        (ifc)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Active-low segment patterns (gfedcba)
    localparam logic [6:0] S_BLANK = 7'b1111111;
    localparam logic [6:0] S_0     = 7'b1000000;
    localparam logic [6:0] S_1     = 7'b1111001;
    localparam logic [6:0] S_3     = 7'b0110000;
    localparam logic [6:0] S_4     = 7'b0011001;
    localparam logic [6:0] S_5     = 7'b0010010;
    localparam logic [6:0] S_7     = 7'b1111000;
    localparam logic [6:0] S_A     = 7'b0001000;

    int checks = 0;
    int fails  = 0;
    int busy_total = 0;
    logic busy_prev = 1'b0;
    logic [11:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a commit is the falling edge of busy; compare against the oldest expectation.
    always @(negedge sysclk) begin
        if (!fp_clear_n) begin
            busy_prev = 1'b0;
        end else begin
            if (busy_prev && !ifc.busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_commit", {20'd0, ifc.bcd}, 32'hFFFF_FFFF);
                end else begin
                    logic [11:0] e;
                    e = exp_q.pop_front();
                    check("bcd_commit", {20'd0, ifc.bcd}, {20'd0, e});
                end
            end
            busy_prev = ifc.busy;
            if (ifc.busy) busy_total++;
        end
    end

    task automatic convert(input logic [7:0] v, input logic [11:0] e);
        int n;
        @(negedge sysclk);
        ifc.value = v;
        exp_q.push_back(e);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge sysclk);
            if (ifc.busy) n++;
            else break;
        end
        check("busy_cycles", n, 8);
        repeat (2) @(negedge sysclk);
    endtask

    task automatic disp_check(input int d, input logic [6:0] exp_seg, input string name);
        logic [3:0] want;
        bit found;
        want  = ~(4'b0001 << d);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sysclk);
            if (ifc.an == want) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) check({name, "_slot_timeout"}, {28'd0, ifc.an}, {28'd0, want});
        else        check(name, {25'd0, ifc.seg}, {25'd0, exp_seg});
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !ifc.busy) break;
            @(negedge sysclk);
        end
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int base;
        logic [3:0] an_seq [0:4];
        an_seq[0] = 4'b1110; an_seq[1] = 4'b1101; an_seq[2] = 4'b1011;
        an_seq[3] = 4'b0111; an_seq[4] = 4'b1110;

        fp_clear_n   = 1'b0;
        ifc.value    = 8'd0;
        ifc.hex_mode = 1'b0;

        // Reset state
        @(negedge sysclk);
        check("rst_an",   {28'd0, ifc.an},  {28'd0, 4'b1110});
        check("rst_seg",  {25'd0, ifc.seg}, {25'd0, S_0});
        check("rst_bcd",  {20'd0, ifc.bcd}, 32'd0);
        check("rst_busy", {31'd0, ifc.busy}, 32'd0);
        #2 fp_clear_n = 1'b1;
        repeat (12) @(negedge sysclk);
        check("no_conv_after_rst", busy_total, 0);

        // Decimal 173
        convert(8'd173, 12'h173);
        disp_check(0, S_3, "d173_d0");
        disp_check(1, S_7, "d173_d1");
        disp_check(2, S_1, "d173_d2");
        disp_check(3, S_BLANK, "d173_d3");

        // Leading-zero blanking
        convert(8'd5, 12'h005);
        disp_check(0, S_5, "d5_d0");
        disp_check(1, S_BLANK, "d5_d1");
        disp_check(2, S_BLANK, "d5_d2");

        convert(8'd40, 12'h040);
        disp_check(0, S_0, "d40_d0");
        disp_check(1, S_4, "d40_d1");
        disp_check(2, S_BLANK, "d40_d2");

        convert(8'd255, 12'h255);

        // Hex mode: 0xA7 = 167
        convert(8'hA7, 12'h167);
        base = busy_total;
        @(negedge sysclk);
        ifc.hex_mode = 1'b1;
        repeat (2) @(negedge sysclk);
        disp_check(1, S_A, "hex_d1");
        disp_check(0, S_7, "hex_d0");
        disp_check(2, S_BLANK, "hex_d2");
        check("hex_no_busy", busy_total - base, 0);
        @(negedge sysclk);
        ifc.hex_mode = 1'b0;
        repeat (2) @(negedge sysclk);
        disp_check(2, S_1, "dec_back_d2");

        // Change during conversion
        base = busy_total;
        @(negedge sysclk);
        ifc.value = 8'd10;
        exp_q.push_back(12'h010);
        repeat (3) @(negedge sysclk);
        ifc.value = 8'd99;
        exp_q.push_back(12'h099);
        wait_drain(60);
        repeat (2) @(negedge sysclk);
        check("busy_total_16", busy_total - base, 16);
        check("final_99", {20'd0, ifc.bcd}, 32'h099);

        // Refresh sequence: sync to the edge where digit 0 becomes active
        for (int i = 0; i < 20 && ifc.an == 4'b1110; i++) @(negedge sysclk);
        for (int i = 0; i < 20 && ifc.an != 4'b1110; i++) @(negedge sysclk);
        check("an_sync", {28'd0, ifc.an}, {28'd0, 4'b1110});
        for (int k = 1; k <= 4; k++) begin
            repeat (4) @(negedge sysclk);
            check("an_scan", {28'd0, ifc.an}, {28'd0, an_seq[k]});
        end

        // Reset mid-conversion
        @(negedge sysclk);
        ifc.value = 8'd42;
        repeat (3) @(negedge sysclk);
        check("busy_before_rst", {31'd0, ifc.busy}, 32'd1);
        #2 fp_clear_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, ifc.busy}, 32'd0);
        check("midrst_bcd",  {20'd0, ifc.bcd}, 32'd0);
        repeat (2) @(negedge sysclk);
        exp_q.push_back(12'h042);
        #2 fp_clear_n = 1'b1;
        wait_drain(40);
        repeat (2) @(negedge sysclk);
        check("after_rst_42", {20'd0, ifc.bcd}, 32'h042);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
